// File: rtl/debounce_edge.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module  : debounce_edge
// | Brief   : Synchronizes a raw bouncing input, commits a level change only after
// |           it has stayed stable, and emits one-clock rise/fall pulses on commit.
// | Revision: 1.0 - initial release
// +-----------------------------------------------------------------------------
module debounce_edge #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    CHK_HIGH  = 2'd1,
    IDLE_HIGH = 2'd2,
    CHK_LOW   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_dout;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Pulses default low every cycle; only a commit raises one for a single clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
      r_dout  <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        IDLE_LOW: begin
          if (w_s) begin
            r_state <= CHK_HIGH;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        CHK_HIGH: begin
          if (!w_s) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == c_cnt_last) begin
            r_state <= IDLE_HIGH;
            r_cnt   <= '0;
            r_dout  <= 1'b1;
            r_rise  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        IDLE_HIGH: begin
          if (!w_s) begin
            r_state <= CHK_LOW;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        CHK_LOW: begin
          if (w_s) begin
            r_state <= IDLE_HIGH;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == c_cnt_last) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            r_dout  <= 1'b0;
            r_fall  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE_LOW;
          r_cnt   <= '0;
          r_dout  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dout = r_dout;
  assign rise = r_rise;
  assign fall = r_fall;
  assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_debounce_edge.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module  : tb_debounce_edge
// | Brief   : Directed and randomized checks of debounce_edge against a
// |           run-length reference model.
// | Revision: 1.0 - initial release
// +-----------------------------------------------------------------------------
module tb_debounce_edge;

  localparam int SYNC_STAGES   = 2;
  localparam int STABLE_CYCLES = 4;
  localparam int CNT_W         = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic din   = 1'b0;
  logic dout, rise, fall, busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: delay line for the synchronizer, plus the length of the current
  // run of synchronized samples that disagree with the committed level.
  logic m_sync [SYNC_STAGES];
  int   m_run;
  logic m_dout, m_rise, m_fall;

  debounce_edge #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (din),
    .dout (dout),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".dout"}, dout, m_dout);
    chk({tag, ".rise"}, rise, m_rise);
    chk({tag, ".fall"}, fall, m_fall);
    chk({tag, ".busy"}, busy, logic'(m_run != 0));
  endtask

  task automatic model_reset();
    for (int i = 0; i < SYNC_STAGES; i++) m_sync[i] = 1'b0;
    m_run  = 0;
    m_dout = 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
  endtask

  task automatic model_edge();
    logic s_pre;
    s_pre = m_sync[SYNC_STAGES-1];
    for (int i = SYNC_STAGES - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = din;
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (s_pre !== m_dout) begin
      m_run++;
      if (m_run == STABLE_CYCLES + 1) begin
        m_dout = s_pre;
        m_rise = s_pre;
        m_fall = ~s_pre;
        m_run  = 0;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic tick(input logic d, input string tag);
    din = d;
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    chk_all(tag);
  endtask

  // Entered one time unit after a rising edge; asserts reset between edges.
  task automatic pulse_reset(input string tag);
    #1 rst_n = 1'b0;
    #1 model_reset();
    chk_all({tag, ".async"});
    @(posedge clk);
    #1 chk_all({tag, ".held"});
    #3 rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    #1 chk_all("reset_async");
    repeat (2) @(posedge clk);
    #1 chk_all("reset_held");
    #3 rst_n = 1'b1;

    // Idle low after release
    for (int k = 1; k <= 20; k++) tick(1'b0, "idle");

    // Clean 0->1 change
    for (int k = 1; k <= 8; k++) begin
      tick(1'b1, "rise_seq");
      chk("rise_seq.busy_win", busy, logic'(k >= 3 && k <= 6));
      chk("rise_seq.rise_at7", rise, logic'(k == 7));
      chk("rise_seq.dout_at7", dout, logic'(k >= 7));
    end
    for (int k = 1; k <= 4; k++) tick(1'b1, "hold_high");

    // Clean 1->0 change
    for (int k = 1; k <= 8; k++) begin
      tick(1'b0, "fall_seq");
      chk("fall_seq.fall_at7", fall, logic'(k == 7));
      chk("fall_seq.dout_at7", dout, logic'(k < 7));
      chk("fall_seq.no_rise", rise, 1'b0);
    end

    // Short glitch high never commits
    for (int k = 1; k <= 11; k++) begin
      tick(logic'(k <= 3), "glitch");
      chk("glitch.dout", dout, 1'b0);
      chk("glitch.rise", rise, 1'b0);
    end
    chk("glitch.busy_end", busy, 1'b0);

    // Reversion in the would-be commit cycle, then a clean hold
    for (int k = 1; k <= 14; k++) begin
      tick(logic'(k != 5), "abort_last");
      chk("abort_last.rise", rise, logic'(k == 12));
      chk("abort_last.dout", dout, logic'(k >= 12));
    end
    for (int k = 1; k <= 8; k++) tick(1'b0, "back_low");

    // Reset during qualification, then requalify from scratch
    for (int k = 1; k <= 4; k++) tick(1'b1, "pre_reset");
    chk("pre_reset.busy", busy, 1'b1);
    pulse_reset("mid_chk");
    for (int k = 1; k <= 8; k++) begin
      tick(1'b1, "post_reset");
      chk("post_reset.rise_at7", rise, logic'(k == 7));
    end

    // Randomized bursts with occasional resets
    for (int b = 0; b < 300; b++) begin
      logic v;
      int   len;
      v   = logic'($urandom_range(0, 1));
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) tick(v, "rand");
      if ($urandom_range(0, 39) == 0) pulse_reset("rand_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
